// File: rtl/board_mem_arbiter.sv
// Round-robin arbiter sharing the single-port board-state RAM between two Avalon-MM masters.
// Optional grant locking for atomic read-modify-write is enabled with `define ARB_LOCK_EN.
module board_mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
`ifdef ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata
);

   logic              w_req0, w_req1, w_gnt0, w_gnt1, w_acc0, w_acc1, w_acc;
   logic              w_sel_wr, w_sel_rd;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              r_last;
   logic [ADDR_W-1:0] r_saddr;
   logic [DATA_W-1:0] r_swdata;
   logic              r_swrite;
   logic [RD_LAT:0]   r_vld_pipe;
   logic [RD_LAT:0]   r_id_pipe;
   logic [DATA_W-1:0] r_rd0, r_rd1;
   logic              r_rdv0, r_rdv1;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
   typedef enum logic [1:0] {FREE, OWN0, OWN1} lock_t;
   lock_t r_lock, w_lock_nxt;

   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) r_lock <= FREE;
      else                r_lock <= w_lock_nxt;

   always_comb begin
      w_gnt0     = 1'b0;
      w_gnt1     = 1'b0;
      w_lock_nxt = r_lock;
      case (r_lock)
         OWN0: begin
            w_gnt0 = w_req0;
            if (~m0_lock & (w_acc0 | ~w_req0)) w_lock_nxt = FREE;
         end
         OWN1: begin
            w_gnt1 = w_req1;
            if (~m1_lock & (w_acc1 | ~w_req1)) w_lock_nxt = FREE;
         end
         default: begin
            w_gnt0 = w_req0 & (~w_req1 | r_last);
            w_gnt1 = w_req1 & ~w_gnt0;
            if (w_acc0 & m0_lock)      w_lock_nxt = OWN0;
            else if (w_acc1 & m1_lock) w_lock_nxt = OWN1;
         end
      endcase
   end
`else
   // r_last=1 means m1 was granted last, so m0 wins a tie
   assign w_gnt0 = w_req0 & (~w_req1 | r_last);
   assign w_gnt1 = w_req1 & ~w_gnt0;
`endif

   assign w_acc0 = w_gnt0 & reset_reset_n;
   assign w_acc1 = w_gnt1 & reset_reset_n;
   assign w_acc  = w_acc0 | w_acc1;
   assign m0_waitrequest = ~w_acc0;
   assign m1_waitrequest = ~w_acc1;

   assign w_sel_addr  = w_acc1 ? m1_address   : m0_address;
   assign w_sel_wdata = w_acc1 ? m1_writedata : m0_writedata;
   assign w_sel_wr    = w_acc1 ? m1_write     : m0_write;
   // a simultaneous read+write issues only the write
   assign w_sel_rd    = (w_acc1 ? m1_read : m0_read) & ~w_sel_wr;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_last     <= 1'b1;
         r_saddr    <= '0;
         r_swdata   <= '0;
         r_swrite   <= 1'b0;
         r_vld_pipe <= '0;
         r_id_pipe  <= '0;
         r_rd0      <= '0;
         r_rd1      <= '0;
         r_rdv0     <= 1'b0;
         r_rdv1     <= 1'b0;
      end else begin
         r_swrite   <= w_acc & w_sel_wr;
         // stage 0 is the s_read cycle; stage RD_LAT lines up with s_readdata
         r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_acc & w_sel_rd};
         r_id_pipe  <= {r_id_pipe[RD_LAT-1:0], w_acc1};
         if (w_acc) begin
            r_last   <= w_acc1;
            r_saddr  <= w_sel_addr;
            r_swdata <= w_sel_wdata;
         end
         r_rdv0 <= r_vld_pipe[RD_LAT] & ~r_id_pipe[RD_LAT];
         r_rdv1 <= r_vld_pipe[RD_LAT] &  r_id_pipe[RD_LAT];
         if (r_vld_pipe[RD_LAT] & ~r_id_pipe[RD_LAT]) r_rd0 <= s_readdata;
         if (r_vld_pipe[RD_LAT] &  r_id_pipe[RD_LAT]) r_rd1 <= s_readdata;
      end
   end

   assign s_address        = r_saddr;
   assign s_read           = r_vld_pipe[0];
   assign s_write          = r_swrite;
   assign s_writedata      = r_swdata;
   assign m0_readdata      = r_rd0;
   assign m1_readdata      = r_rd1;
   assign m0_readdatavalid = r_rdv0;
   assign m1_readdatavalid = r_rdv1;

`ifndef SYNTHESIS
   always_ff @(posedge clk_clk)
      if (reset_reset_n && ((m0_read && m0_write) || (m1_read && m1_write)))
         $error("board_mem_arbiter: read and write asserted together; read ignored");
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a RAM behaviour model on the slave side and a
// specification-level reference model checked every cycle, plus literal spot checks.
module tb_board_mem_arbiter;
   localparam int RD_LAT = 2;

   logic        clk, rst_n;
   logic [5:0]  m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write;
   logic [31:0] s_writedata, s_readdata;
`ifdef ARB_LOCK_EN
   logic        m0_lock, m1_lock;
`endif

   int vec = 0, errs = 0;
   int rdv0_cnt = 0, rdv1_cnt = 0;

   typedef struct { bit port; logic [31:0] data; int due; } rd_t;
   rd_t q[$];

   board_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
`ifdef ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return (i == 5) ? 32'hDEAD_BEEF : (32'hA500_0000 | i);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Slave RAM: read data appears RD_LAT cycles after s_read
   logic [31:0] ram [64];
   logic [31:0] rpipe [1:RD_LAT];
   logic        ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (s_write) ram[s_address] <= s_writedata;
      rpipe[1] <= ram[s_address];
      for (int k = 2; k <= RD_LAT; k++) rpipe[k] <= rpipe[k-1];
   end
   assign s_readdata = rpipe[RD_LAT];

   // Reference model: arbitration rules, expected memory image, ordered read returns
   initial begin
      logic [31:0] mdl [64];
      int n, owner;
      bit ptr, esr, esw, r0, r1, g0, g1, l0, l1, p, wr, rd, v0, v1, lo, ro;
      logic [5:0]  esa, addr;
      logic [31:0] esd, erd0, erd1, wd;
      rd_t e;
      n = 0; owner = -1; ptr = 1'b1; esr = 1'b0; esw = 1'b0;
      esa = '0; esd = '0; erd0 = '0; erd1 = '0;
      for (int i = 0; i < 64; i++) mdl[i] = init_val(i);
      forever begin
         @(negedge clk);
         n++;
         if (!rst_n) begin
            chk("rst_wait0", m0_waitrequest, 1);
            chk("rst_wait1", m1_waitrequest, 1);
            chk("rst_sread", s_read, 0);
            chk("rst_swrite", s_write, 0);
            chk("rst_saddr", s_address, 0);
            chk("rst_swdata", s_writedata, 0);
            chk("rst_rdv0", m0_readdatavalid, 0);
            chk("rst_rdv1", m1_readdatavalid, 0);
            chk("rst_rd0", m0_readdata, 0);
            chk("rst_rd1", m1_readdata, 0);
            q.delete();
            ptr = 1'b1; owner = -1; esr = 1'b0; esw = 1'b0;
            esa = '0; esd = '0; erd0 = '0; erd1 = '0;
         end else begin
            chk("s_read", s_read, esr);
            chk("s_write", s_write, esw);
            if (esr || esw) chk("s_address", s_address, esa);
            if (esw) chk("s_writedata", s_writedata, esd);
            v0 = 1'b0; v1 = 1'b0;
            if (q.size() > 0 && q[0].due == n) begin
               e = q.pop_front();
               if (e.port) begin v1 = 1'b1; erd1 = e.data; end
               else        begin v0 = 1'b1; erd0 = e.data; end
            end
            chk("rdv0", m0_readdatavalid, v0);
            chk("rdv1", m1_readdatavalid, v1);
            chk("readdata0", m0_readdata, erd0);
            chk("readdata1", m1_readdata, erd1);
            if (m0_readdatavalid) rdv0_cnt++;
            if (m1_readdatavalid) rdv1_cnt++;

            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
`ifdef ARB_LOCK_EN
            l0 = m0_lock; l1 = m1_lock;
`else
            l0 = 1'b0; l1 = 1'b0;
`endif
            if (owner == 0)      begin g0 = r0; g1 = 1'b0; end
            else if (owner == 1) begin g0 = 1'b0; g1 = r1; end
            else begin
               g0 = r0 && (!r1 || ptr);
               g1 = r1 && !g0;
            end
            chk("wait0", m0_waitrequest, !g0);
            chk("wait1", m1_waitrequest, !g1);

            if (g0 || g1) begin
               p    = g1;
               addr = p ? m1_address : m0_address;
               wr   = p ? m1_write : m0_write;
               rd   = p ? m1_read : m0_read;
               wd   = p ? m1_writedata : m0_writedata;
               esa = addr; esd = wd; esw = wr; esr = rd && !wr; ptr = p;
               if (wr) mdl[addr] = wd;
               else begin
                  e.port = p; e.data = mdl[addr]; e.due = n + RD_LAT + 2;
                  q.push_back(e);
               end
            end else begin
               esr = 1'b0; esw = 1'b0;
            end
            if (owner >= 0) begin
               lo = (owner == 0) ? l0 : l1;
               ro = (owner == 0) ? r0 : r1;
               if (!lo && (g0 || g1 || !ro)) owner = -1;
            end else if (g0 && l0) owner = 0;
            else if (g1 && l1) owner = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      int c0, c1;
      rst_n = 1'b1;
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
`ifdef ARB_LOCK_EN
      m0_lock = 0; m1_lock = 0;
`endif
      #1 rst_n = 1'b0;
      // reset held with a pending m0 read
      m0_address = 6'd3; m0_read = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("t1_wait_in_reset", m0_waitrequest, 1);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_accept", m0_waitrequest, 0);
      step();
      m0_read = 1'b0;
      @(negedge clk);
      chk("t1_sread", s_read, 1);
      chk("t1_saddr", s_address, 6'd3);
      repeat (RD_LAT + 4) step();

      // single read from m1
      m1_address = 6'd5; m1_read = 1'b1;
      step();
      m1_read = 1'b0;
      repeat (RD_LAT + 2) @(negedge clk);
      chk("t2_rdv1", m1_readdatavalid, 1);
      chk("t2_data1", m1_readdata, 32'hDEAD_BEEF);
      chk("t2_m0_hold", m0_readdata, 32'hA500_0003);
      repeat (RD_LAT + 2) step();

      // contention: both read for 8 cycles
      c0 = rdv0_cnt; c1 = rdv1_cnt;
      m0_address = 6'd10; m1_address = 6'd11; m0_read = 1'b1; m1_read = 1'b1;
      repeat (8) step();
      m0_read = 1'b0; m1_read = 1'b0;
      repeat (RD_LAT + 4) step();
      chk("t3_cnt0", rdv0_cnt - c0, 4);
      chk("t3_cnt1", rdv1_cnt - c1, 4);
      chk("t3_data0", m0_readdata, 32'hA500_000A);
      chk("t3_data1", m1_readdata, 32'hA500_000B);

      // write then read of the same square from the other port
      m0_address = 6'd9; m0_writedata = 32'h12; m0_write = 1'b1;
      m1_address = 6'd9; m1_read = 1'b1;
      step();
      m0_write = 1'b0;
      step();
      m1_read = 1'b0;
      repeat (RD_LAT + 4) step();
      chk("t4_ordering", m1_readdata, 32'h12);

      // reset one cycle after a read is accepted drops that read
      c0 = rdv0_cnt;
      m0_address = 6'd7; m0_read = 1'b1;
      step();
      m0_read = 1'b0; rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (RD_LAT + 6) step();
      chk("t5_no_rdv", rdv0_cnt - c0, 0);
      chk("t5_rd0_clear", m0_readdata, 0);

`ifdef ARB_LOCK_EN
      // locked read-modify-write by m0 while m1 waits
      m0_address = 6'd20; m0_read = 1'b1; m0_lock = 1'b1;
      m1_address = 6'd21; m1_read = 1'b1;
      step();
      m0_read = 1'b0;
      @(negedge clk);
      chk("t6_m1_held_idle", m1_waitrequest, 1);
      step();
      m0_write = 1'b1; m0_writedata = 32'h55; m0_lock = 1'b0;
      @(negedge clk);
      chk("t6_m1_held_wr", m1_waitrequest, 1);
      step();
      m0_write = 1'b0;
      @(negedge clk);
      chk("t6_m1_accept", m1_waitrequest, 0);
      step();
      m1_read = 1'b0;
      repeat (RD_LAT + 4) step();
`endif

      chk("drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
